// File: rtl/boot_fetch.sv
// boot_fetch: fetch stage in front of a combinational boot ROM. Owns the PC,
//   captures {pc, instruction} into a 2-entry buffer and hands it to decode.
// Latency: an instruction is on out_* one cycle after its pc is presented.
// Backpressure: out_ready low lets the buffer fill to 2, after which the PC holds;
//   nothing is lost or duplicated. A jump flushes the buffer and redirects the PC.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   pc                  registered fetch address to the ROM
//   instruction         ROM data for pc, same cycle
//   jump, jump_addr     redirect request and target (jump beats fetch)
//   out_valid/out_ready valid/ready handshake to decode
//   out_instr, out_pc   buffer head: instruction and the address it came from
//   fault               sticky out-of-range fetch flag
//
// Build option: define FETCH_BOUNDS_EN to enable the ROM bounds check. Without it,
// fault is constant 0 and out-of-range PCs fetch normally (the ROM aliases them).

module boot_fetch #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter int          ROM_ABITS = 8
) (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] pc,
   input  logic [15:0] instruction,
   input  logic        jump,
   input  logic [15:0] jump_addr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_instr,
   output logic [15:0] out_pc,
   output logic        fault
);

`ifdef FETCH_BOUNDS_EN
   localparam bit BOUNDS_EN = 1'b1;
`else
   localparam bit BOUNDS_EN = 1'b0;
`endif

   // Buffer is a two-slot shift register: slot 0 is always the head, so the
   // outputs come straight from registers and simply hold when the buffer empties.
   logic [15:0] r_pc;
   logic [1:0]  r_count;
   logic [15:0] r_pc0;
   logic [15:0] r_ins0;
   logic [15:0] r_pc1;
   logic [15:0] r_ins1;
   logic        r_fault;

   logic        w_oob;
   logic        w_halted;
   logic        w_pop;
   logic        w_fetch;
   logic        w_take;
   logic        w_push;
   logic        w_fault_set;

   // Address beyond the ROM window; constant 0 when the check is built out.
   assign w_oob    = BOUNDS_EN && ((r_pc >> ROM_ABITS) != 16'd0);
   assign w_halted = r_fault;

   always_comb begin
      w_pop       = 1'b0;
      w_fetch     = 1'b0;
      w_take      = 1'b0;
      w_push      = 1'b0;
      w_fault_set = 1'b0;

      w_pop   = (r_count != 2'd0) && out_ready;
      // A slot is free now, or one frees up this cycle because the head leaves.
      w_fetch = !w_halted && ((r_count != 2'd2) || w_pop);
      // Jump pre-empts the fetch: nothing is pushed in the redirect cycle.
      w_take  = w_fetch && !jump;
      w_push  = w_take && !w_oob;
      // An out-of-range fetch is dropped and raises fault. The PC stays on the
      // offending address, which is useful when inspecting a halted core.
      w_fault_set = w_take && w_oob;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc    <= RESET_PC;
         r_count <= 2'd0;
         r_pc0   <= 16'h0000;
         r_ins0  <= 16'h0000;
         r_pc1   <= 16'h0000;
         r_ins1  <= 16'h0000;
         r_fault <= 1'b0;
      end else begin
         if (w_fault_set) begin
            r_fault <= 1'b1;
         end

         if (jump) begin
            // Flush: a head popped in this cycle is still consumed; the rest is
            // dropped. Slot contents are left alone so out_* keep their last value.
            r_count <= 2'd0;
            r_pc    <= jump_addr;
         end else begin
            if (w_push) begin
               r_pc <= r_pc + 16'd1;
            end

            case ({w_pop, w_push})
               2'b10: begin
                  r_count <= r_count - 2'd1;
                  if (r_count == 2'd2) begin
                     r_pc0  <= r_pc1;
                     r_ins0 <= r_ins1;
                  end
               end
               2'b01: begin
                  r_count <= r_count + 2'd1;
                  if (r_count == 2'd0) begin
                     r_pc0  <= r_pc;
                     r_ins0 <= instruction;
                  end else begin
                     r_pc1  <= r_pc;
                     r_ins1 <= instruction;
                  end
               end
               2'b11: begin
                  // Count unchanged; the new entry lands behind whatever remains.
                  if (r_count == 2'd1) begin
                     r_pc0  <= r_pc;
                     r_ins0 <= instruction;
                  end else begin
                     r_pc0  <= r_pc1;
                     r_ins0 <= r_ins1;
                     r_pc1  <= r_pc;
                     r_ins1 <= instruction;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign pc        = r_pc;
   assign out_valid = (r_count != 2'd0);
   assign out_instr = r_ins0;
   assign out_pc    = r_pc0;
   assign fault     = r_fault;

endmodule
